// File: rtl/lab2_proc_pkg.sv
// lab2_proc_pkg: shared types and constants for the processor units
package lab2_proc_pkg;

    localparam int IMUL_NBITS = 32;

    typedef enum logic [1:0] {IMUL_IDLE, IMUL_CALC, IMUL_DONE} imul_state_t;

endpackage

// File: rtl/lab2_proc_imul_ctrl.sv
// lab2_proc_imul_ctrl: IDLE/CALC/DONE sequencing and val/rdy handshakes
module lab2_proc_imul_ctrl
    import lab2_proc_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_val,
    input  logic resp_rdy,
    input  logic b_next_zero,
    input  logic count_last,
    output logic load,
    output logic step,
    output logic req_rdy,
    output logic resp_val
);

    imul_state_t state;

    // state and registered handshake outputs advance together
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IMUL_IDLE;
            req_rdy  <= 1'b1;
            resp_val <= 1'b0;
        end else begin
            unique case (state)
                IMUL_IDLE: if (req_val) begin
                    state   <= IMUL_CALC;
                    req_rdy <= 1'b0;
                end
                IMUL_CALC: if (b_next_zero || count_last) begin
                    state    <= IMUL_DONE;
                    resp_val <= 1'b1;
                end
                IMUL_DONE: if (resp_rdy) begin
                    state    <= IMUL_IDLE;
                    resp_val <= 1'b0;
                    req_rdy  <= 1'b1;
                end
                default: begin
                    state    <= IMUL_IDLE;
                    resp_val <= 1'b0;
                    req_rdy  <= 1'b1;
                end
            endcase
        end
    end

    assign load = req_rdy & req_val;
    assign step = state == IMUL_CALC;

endmodule

// File: rtl/lab2_proc_imul_dpath.sv
// lab2_proc_imul_dpath: operand registers, partial-product accumulator and step counter
module lab2_proc_imul_dpath
    import lab2_proc_pkg::*;
#(
    parameter int NBITS = IMUL_NBITS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [NBITS-1:0] a,
    input  logic [NBITS-1:0] b,
    output logic             b_next_zero,
    output logic             count_last,
    output logic [NBITS-1:0] result
);

    localparam int CW = $clog2(NBITS);

    logic [NBITS-1:0] a_reg;
    logic [NBITS-1:0] b_reg;
    logic [CW-1:0]    count;

    // load a fresh operand pair, or consume one multiplier bit per step
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg  <= '0;
            b_reg  <= '0;
            result <= '0;
            count  <= '0;
        end else if (load) begin
            a_reg  <= a;
            b_reg  <= b;
            result <= '0;
            count  <= '0;
        end else if (step) begin
            if (b_reg[0])
                result <= result + a_reg;
            a_reg <= a_reg << 1;
            b_reg <= b_reg >> 1;
            count <= count + CW'(1);
        end
    end

    assign b_next_zero = (b_reg >> 1) == '0;
    assign count_last  = count == CW'(NBITS - 1);

endmodule

// File: rtl/lab2_proc_imul_unit.sv
// lab2_proc_imul_unit: iterative shift-add multiplier returning the low NBITS of a*b
module lab2_proc_imul_unit
    import lab2_proc_pkg::*;
#(
    parameter int NBITS = IMUL_NBITS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_val,
    output logic               req_rdy,
    input  logic [2*NBITS-1:0] req_msg,
    output logic               resp_val,
    input  logic               resp_rdy,
    output logic [NBITS-1:0]   resp_msg
);

    logic load;
    logic step;
    logic b_next_zero;
    logic count_last;

    lab2_proc_imul_ctrl ctrl (
        .clk         (clk),
        .reset       (reset),
        .req_val     (req_val),
        .resp_rdy    (resp_rdy),
        .b_next_zero (b_next_zero),
        .count_last  (count_last),
        .load        (load),
        .step        (step),
        .req_rdy     (req_rdy),
        .resp_val    (resp_val)
    );

    lab2_proc_imul_dpath #(.NBITS(NBITS)) dpath (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .step        (step),
        .a           (req_msg[2*NBITS-1:NBITS]),
        .b           (req_msg[NBITS-1:0]),
        .b_next_zero (b_next_zero),
        .count_last  (count_last),
        .result      (resp_msg)
    );

endmodule

// File: tb/tb_lab2_proc_imul_unit.sv
// tb_lab2_proc_imul_unit: directed vectors, corner sequences and a random stream against a product model
module tb_lab2_proc_imul_unit;

    localparam int N = 32;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           req_val = 1'b0;
    logic           req_rdy;
    logic [2*N-1:0] req_msg = '0;
    logic           resp_val;
    logic           resp_rdy = 1'b0;
    logic [N-1:0]   resp_msg;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        int           hold;
        logic [N-1:0] exp_msg;
        int           exp_lat;
    } vec_t;

    vec_t vecs[9];

    lab2_proc_imul_unit #(.NBITS(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .req_val  (req_val),
        .req_rdy  (req_rdy),
        .req_msg  (req_msg),
        .resp_val (resp_val),
        .resp_rdy (resp_rdy),
        .resp_msg (resp_msg)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [2*N-1:0] p;
        p = {{N{1'b0}}, a} * {{N{1'b0}}, b};
        return p[N-1:0];
    endfunction

    // clock edges from acceptance to resp_val: 1 + max(1, highest set bit index + 1)
    function automatic int ref_lat(input logic [N-1:0] b);
        int k;
        k = 1;
        for (int i = 0; i < N; i++)
            if (b[i]) k = i + 1;
        return 1 + k;
    endfunction

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input int hold,
                          output logic [N-1:0] msg, output int lat);
        int w;
        w = 0;
        @(negedge clk);
        while (!req_rdy && w < 100) begin
            @(negedge clk);
            w++;
        end
        req_val = 1'b1;
        req_msg = {a, b};
        resp_rdy = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            req_val = 1'b0;
            lat++;
        end while (!resp_val && lat < 100);
        msg = resp_msg;
        for (int i = 0; i < hold; i++) begin
            chk("hold_resp_val", resp_val, 1);
            chk("hold_resp_msg", resp_msg, ref_mul(a, b));
            chk("hold_req_rdy", req_rdy, 0);
            @(negedge clk);
        end
        resp_rdy = 1'b1;
        @(negedge clk);
        resp_rdy = 1'b0;
    endtask

    initial begin
        logic [N-1:0] msg;
        int lat;
        int seen;
        logic [N-1:0] exp_q[$];
        int sent, got, gap, cyc;
        logic [N-1:0] ra, rb;

        vecs[0] = '{32'd3,        32'd4,        0, 32'd12,       4};
        vecs[1] = '{32'h1234,     32'd0,        0, 32'd0,        2};
        vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'd1,        33};
        vecs[3] = '{32'd7,        32'd6,        5, 32'd42,       4};
        vecs[4] = '{32'hFFFFFFFF, 32'd1,        0, 32'hFFFFFFFF, 2};
        vecs[5] = '{32'd9,        32'd2,        0, 32'd18,       3};
        vecs[6] = '{32'd1,        32'h80000000, 0, 32'h80000000, 33};
        vecs[7] = '{32'h80000000, 32'h80000001, 0, 32'h80000000, 33};
        vecs[8] = '{32'd0,        32'h0000FFFF, 1, 32'd0,        17};

        @(negedge clk);
        chk("reset_req_rdy", req_rdy, 1);
        chk("reset_resp_val", resp_val, 0);
        chk("reset_resp_msg", resp_msg, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_no_req_rdy", req_rdy, 1);
        chk("idle_no_req_val", resp_val, 0);

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].hold, msg, lat);
            chk($sformatf("vec%0d_msg", i), msg, vecs[i].exp_msg);
            chk($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
            chk($sformatf("vec%0d_idle_rdy", i), req_rdy, 1);
            chk($sformatf("vec%0d_idle_val", i), resp_val, 0);
        end

        // reset three cycles into a long multiply
        @(negedge clk);
        req_val = 1'b1;
        req_msg = {32'h80000000, 32'h80000001};
        @(negedge clk);
        req_val = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_calc_busy", req_rdy, 0);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_req_rdy", req_rdy, 1);
        chk("async_reset_resp_val", resp_val, 0);
        chk("async_reset_resp_msg", resp_msg, 0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (resp_val) seen++;
        end
        chk("no_resp_after_reset", seen, 0);
        run_op(32'd5, 32'd5, 0, msg, lat);
        chk("post_reset_msg", msg, 32'd25);
        chk("post_reset_lat", lat, ref_lat(32'd5));

        // random stream with random request gaps and response backpressure
        sent = 0;
        got = 0;
        gap = 0;
        cyc = 0;
        while (got < 200 && cyc < 30000) begin
            @(negedge clk);
            cyc++;
            if (req_val) req_val = 1'b0;
            if (resp_val) begin
                resp_rdy = ($urandom_range(0, 2) != 0);
                if (resp_rdy) begin
                    if (exp_q.size() == 0) begin
                        chk("rand_unexpected_resp", 1, 0);
                    end else begin
                        chk($sformatf("rand%0d_msg", got), resp_msg, exp_q.pop_front());
                    end
                    got++;
                end
            end else begin
                resp_rdy = 1'b0;
            end
            if (req_rdy && sent < 200) begin
                if (gap > 0) begin
                    gap--;
                end else begin
                    ra = $urandom;
                    rb = $urandom >> $urandom_range(0, 31);
                    req_val = 1'b1;
                    req_msg = {ra, rb};
                    exp_q.push_back(ref_mul(ra, rb));
                    sent++;
                    gap = $urandom_range(0, 3);
                end
            end
        end
        chk("rand_all_responses", got, 200);
        chk("rand_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
